apb_master_arbiter: RTL and testbench

//  APB master that shares one APB slave port between NUM_REQ local requesters.

---
 rtl/apb_master_arbiter_if.sv | 36 +++
 rtl/apb_master_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB bus bundle between the shared master and its slave
interface apb_master_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  PSEL;
   logic                  PENABLE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL,
      output PENABLE,
      output PADDR,
      output PWRITE,
      output PWDATA,
      input  PRDATA,
      input  PREADY,
      input  PSLVERR
   );

   modport slave (
      input  PSEL,
      input  PENABLE,
      input  PADDR,
      input  PWRITE,
      input  PWDATA,
      output PRDATA,
      output PREADY,
      output PSLVERR
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master shared by NUM_REQ local requesters
module apb_master_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                          PCLK,
   input  logic                          PRESET,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   apb_master_arbiter_if.master          apb
);
   // Index width for requester numbers; wait counter sized to reach TIMEOUT-1.
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   logic [1:0]            state;
   logic [IDX_W-1:0]      last;
   logic [IDX_W-1:0]      owner;
   logic [IDX_W-1:0]      winner;
   logic [IDX_W-1:0]      cand;
   logic                  found;
   logic                  accept;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  pwrite_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  access_done;
   logic                  access_timeout;

   // Round-robin search starting just after the last winner; first set bit wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Accept strobe exists only while idle, so requests are never lost mid-transfer.
   assign accept = (state == ST_IDLE) && found;

   // One-hot accept pulse to the winning requester.
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[winner] = 1'b1;
      end
   end

   // The transfer ends on PREADY; the timeout only fires when PREADY is still low.
   assign access_done    = (state == ST_ACCESS) && apb.PREADY;
   assign access_timeout = (state == ST_ACCESS) && !apb.PREADY && (cnt == CNT_LAST);

   // Transfer sequencing: IDLE -> SETUP -> ACCESS (waits) -> IDLE.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (access_done || access_timeout) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Round-robin pointer and transfer owner, both updated on the accept edge.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         last  <= LAST_INIT;
         owner <= '0;
      end else if (accept) begin
         last  <= winner;
         owner <= winner;
      end
   end

   // ACCESS wait counter, cleared while entering ACCESS and bumped per waited cycle.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cnt <= '0;
      end else if (state == ST_SETUP) begin
         cnt <= '0;
      end else if ((state == ST_ACCESS) && !access_done && !access_timeout) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Capture the winner's command on accept; held through the transfer and while idle.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
      end else if (accept) begin
         paddr_q  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
         pwrite_q <= req_write[winner];
         pwdata_q <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Completion response: one-cycle valid pulse, data and error held until the next one.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (access_done) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= pwrite_q ? '0 : apb.PRDATA;
            rsp_err          <= apb.PSLVERR;
         end else if (access_timeout) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b1;
         end
      end
   end

   // APB control follows the state directly so reset clears PSEL/PENABLE on the next cycle.
   assign apb.PSEL    = (state == ST_SETUP) || (state == ST_ACCESS);
   assign apb.PENABLE = (state == ST_ACCESS);
   assign apb.PADDR   = paddr_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PWDATA  = pwdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - randomized bench with transaction-timing reference model
module tb_apb_master_arbiter;
   localparam int NUM_REQ    = 3;
   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 32;
   localparam int TIMEOUT    = 16;

   logic                          PCLK = 1'b0;
   logic                          PRESET;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic                          rsp_err;

   apb_master_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) apb ();

   apb_master_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .req_valid(req_valid),
      .req_write(req_write),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .apb      (apb)
   );

   initial forever #5 PCLK = ~PCLK;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Requester-side pending requests.
   bit                    pend [NUM_REQ];
   bit                    pw   [NUM_REQ];
   logic [ADDR_WIDTH-1:0] pa   [NUM_REQ];
   logic [DATA_WIDTH-1:0] pd   [NUM_REQ];

   // Transaction-level model: one transfer in flight, described by its accept
   // cycle, its planned slave wait count and the resulting completion cycle.
   int                    last;
   bit                    busy;
   int                    t_acc;
   int                    t_done;
   int                    wait_n;
   int                    own;
   bit                    rsp_due;
   int                    rsp_cyc;
   int                    rsp_own;
   logic [ADDR_WIDTH-1:0] exp_paddr;
   bit                    exp_pwrite;
   logic [DATA_WIDTH-1:0] exp_pwdata;
   logic [DATA_WIDTH-1:0] exp_rdata;
   bit                    exp_err;
   int                    n_resets;
   int                    n_timeouts;

   function automatic int pick_wait();
      int r;
      r = $urandom_range(99);
      if (r < 40)      return 0;
      else if (r < 65) return $urandom_range(3, 1);
      else if (r < 78) return TIMEOUT - 1;
      else if (r < 90) return TIMEOUT;
      else             return $urandom_range(TIMEOUT + 3, 0);
   endfunction

   task automatic model_reset();
      last       = NUM_REQ - 1;
      busy       = 1'b0;
      rsp_due    = 1'b0;
      exp_paddr  = '0;
      exp_pwrite = 1'b0;
      exp_pwdata = '0;
      exp_rdata  = '0;
      exp_err    = 1'b0;
   endtask

   task automatic step(input int p_req, input bit allow_reset);
      int                 win;
      int                 k;
      bit                 in_access;
      bit                 do_rst;
      logic [NUM_REQ-1:0] exp_ready;
      logic [NUM_REQ-1:0] exp_rsp;

      @(negedge PCLK);

      for (int i = 0; i < NUM_REQ; i++) begin
         if (!pend[i] && ($urandom_range(99) < p_req)) begin
            pend[i] = 1'b1;
            pw[i]   = 1'($urandom_range(1));
            pa[i]   = ADDR_WIDTH'($urandom);
            pd[i]   = $urandom;
         end
         req_valid[i] = pend[i];
         req_write[i] = pend[i] ? pw[i] : 1'($urandom_range(1));
         req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = pend[i] ? pa[i] : ADDR_WIDTH'($urandom);
         req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = pend[i] ? pd[i] : $urandom;
      end

      in_access = busy && (cyc >= t_acc + 2);
      if (in_access) begin
         k = cyc - t_acc - 2;
         apb.PREADY = (k == wait_n);
      end else begin
         apb.PREADY = 1'($urandom_range(1));
      end
      apb.PSLVERR = 1'($urandom_range(1));
      apb.PRDATA  = $urandom;

      do_rst = allow_reset && in_access && ($urandom_range(99) < 4);
      PRESET = do_rst;

      #1;
      win = -1;
      if (!busy) begin
         for (int j = 1; j <= NUM_REQ; j++) begin
            if (win < 0 && pend[(last + j) % NUM_REQ]) win = (last + j) % NUM_REQ;
         end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      exp_rsp = '0;
      if (rsp_due && cyc == rsp_cyc) exp_rsp[rsp_own] = 1'b1;

      check_eq("req_ready", req_ready, exp_ready);
      check_eq("psel", apb.PSEL, busy && (cyc >= t_acc + 1));
      check_eq("penable", apb.PENABLE, in_access);
      check_eq("paddr", apb.PADDR, exp_paddr);
      check_eq("pwrite", apb.PWRITE, exp_pwrite);
      check_eq("pwdata", apb.PWDATA, exp_pwdata);
      check_eq("rsp_valid", rsp_valid, exp_rsp);
      check_eq("rsp_rdata", rsp_rdata, exp_rdata);
      check_eq("rsp_err", rsp_err, exp_err);

      if (do_rst) begin
         n_resets++;
         model_reset();
      end else if (win >= 0) begin
         busy       = 1'b1;
         t_acc      = cyc;
         own        = win;
         last       = win;
         pend[win]  = 1'b0;
         exp_paddr  = pa[win];
         exp_pwrite = pw[win];
         exp_pwdata = pd[win];
         wait_n     = pick_wait();
         t_done     = t_acc + 2 + ((wait_n < TIMEOUT) ? wait_n : TIMEOUT - 1);
      end else if (busy && cyc == t_done) begin
         busy    = 1'b0;
         rsp_due = 1'b1;
         rsp_cyc = cyc + 1;
         rsp_own = own;
         if (wait_n < TIMEOUT) begin
            exp_err   = apb.PSLVERR;
            exp_rdata = exp_pwrite ? '0 : apb.PRDATA;
         end else begin
            n_timeouts++;
            exp_err   = 1'b1;
            exp_rdata = '0;
         end
      end
      cyc++;
   endtask

   initial begin
      PRESET      = 1'b1;
      req_valid   = '0;
      req_write   = '0;
      req_addr    = '0;
      req_wdata   = '0;
      apb.PREADY  = 1'b0;
      apb.PSLVERR = 1'b0;
      apb.PRDATA  = '0;
      n_resets    = 0;
      n_timeouts  = 0;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
      model_reset();

      repeat (3) @(negedge PCLK);
      check_eq("reset_psel", apb.PSEL, 1'b0);
      check_eq("reset_penable", apb.PENABLE, 1'b0);
      check_eq("reset_paddr", apb.PADDR, '0);
      check_eq("reset_pwrite", apb.PWRITE, 1'b0);
      check_eq("reset_pwdata", apb.PWDATA, '0);
      check_eq("reset_rsp_valid", rsp_valid, '0);
      check_eq("reset_rsp_rdata", rsp_rdata, '0);
      check_eq("reset_rsp_err", rsp_err, 1'b0);
      check_eq("reset_req_ready", req_ready, '0);
      PRESET = 1'b0;

      repeat (500) step(30, 1'b0);
      repeat (400) step(100, 1'b0);
      repeat (900) step(50, 1'b1);
      repeat (40) step(0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
